fp_normalize_pipe: RTL

Parametrised, pipelined normalise-and-round stage for the floating-point adder. It sits after the align/add stage. It consumes the raw aligned sum plus operand classification, and produces a packed IEEE-754-style result with exception flags. Compared with the single-precision combinational normaliser it adds:
- configurable exponent/mantissa widths;
- four rounding modes;
- a 3-stage valid/ready pipeline with backpressure;
- overflow/underflow/inexact/invalid flags.

---
 rtl/fp_pkg.sv | 44 ++++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_normalize_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and IEEE-754 bit-pattern helpers for the floating-point adder datapath.
package fp_pkg;

    localparam int unsigned FP_MAX_W = 64;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rnd_mode_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Patterns are built at FP_MAX_W and truncated by the caller to 1+exp_w+man_w.
    function automatic logic [FP_MAX_W-1:0] fp_exp_ones(input int unsigned exp_w);
        return (FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1);
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                                     input int unsigned man_w);
        return (fp_exp_ones(exp_w) << man_w) | (FP_MAX_W'(1) << (man_w - 1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign,
                                                    input int unsigned exp_w,
                                                    input int unsigned man_w);
        return (FP_MAX_W'(sign) << (exp_w + man_w)) | (fp_exp_ones(exp_w) << man_w);
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_max_finite(input logic sign,
                                                           input int unsigned exp_w,
                                                           input int unsigned man_w);
        return (FP_MAX_W'(sign) << (exp_w + man_w))
             | ((fp_exp_ones(exp_w) - FP_MAX_W'(1)) << man_w)
             | ((FP_MAX_W'(1) << man_w) - FP_MAX_W'(1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero count; returns W for an all-zero input.
module fp_lzc #(
    parameter  int unsigned W  = 33,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count_c
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count_c = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (value[i]) count_c = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Three-stage normalise/round/pack stage of the FP adder with valid/ready backpressure.
module fp_normalize_pipe
    import fp_pkg::*;
#(
    parameter  int unsigned EXP_W   = 8,
    parameter  int unsigned MAN_W   = 23,
    localparam int unsigned ALIGN_W = MAN_W + 9,
    localparam int unsigned FP_W    = 1 + EXP_W + MAN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic               in_carry,
    input  logic [ALIGN_W-1:0] in_sum,
    input  logic [FP_W-1:0]    in_a,
    input  logic [FP_W-1:0]    in_b,
    input  logic               in_a_nan,
    input  logic               in_b_nan,
    input  logic               in_a_inf,
    input  logic               in_b_inf,
    input  logic               in_a_zero,
    input  logic               in_b_zero,
    input  logic [1:0]         in_rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FP_W-1:0]    out_result,
    output logic [3:0]         out_flags
);

    localparam int unsigned V_W     = ALIGN_W + 1;
    localparam int unsigned LZ_W    = $clog2(V_W + 1);
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    typedef struct packed {
        logic               special;
        logic [FP_W-1:0]    spec_res;
        logic               spec_invalid;
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic               carry;
        logic [ALIGN_W-1:0] sum;
        logic [LZ_W-1:0]    lz;
        rnd_mode_e          rnd;
    } s1_t;

    typedef struct packed {
        logic               special;
        logic [FP_W-1:0]    spec_res;
        logic               spec_invalid;
        logic               sign;
        logic [EW-1:0]      e;
        logic [MAN_W-1:0]   field;
        logic               rcarry;
        logic               inexact;
        rnd_mode_e          rnd;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic s1_valid, s2_valid;
    logic ready2, ready3, s1_moves;
    logic [V_W-1:0]  v;
    logic [LZ_W-1:0] lz;
    logic [FP_W-1:0] res_d;
    fp_flags_t       flags_d;

    assign ready3   = ~out_valid | out_ready;
    assign ready2   = ~s2_valid | ready3;
    assign s1_moves = s1_valid & ready2;
    assign in_ready = ~rst & (~s1_valid | s1_moves);

    assign v = {in_carry, in_sum};

    fp_lzc #(.W(V_W)) u_lzc (
        .value   (v),
        .count_c (lz)
    );

    // S1: special-case resolution in priority order, plus leading-zero count
    always_comb begin
        logic sa, sb;
        rnd_mode_e rnd;
        sa   = in_a[FP_W-1];
        sb   = in_b[FP_W-1];
        rnd  = rnd_mode_e'(in_rnd);
        s1_d = '0;
        s1_d.sign    = in_sign;
        s1_d.exp     = in_exp;
        s1_d.carry   = in_carry;
        s1_d.sum     = in_sum;
        s1_d.lz      = lz;
        s1_d.rnd     = rnd;
        s1_d.special = 1'b1;
        if (in_a_nan) begin
            s1_d.spec_res = in_a;
        end else if (in_b_nan) begin
            s1_d.spec_res = in_b;
        end else if (in_a_inf && in_b_inf && (sa != sb)) begin
            s1_d.spec_res     = FP_W'(fp_qnan(EXP_W, MAN_W));
            s1_d.spec_invalid = 1'b1;
        end else if (in_a_inf) begin
            s1_d.spec_res = in_a;
        end else if (in_b_inf) begin
            s1_d.spec_res = in_b;
        end else if (in_a_zero && in_b_zero) begin
            s1_d.spec_res = (sa == sb) ? in_a : {(rnd == RDN), {(FP_W-1){1'b0}}};
        end else if (in_a_zero) begin
            s1_d.spec_res = in_b;
        end else if (in_b_zero) begin
            s1_d.spec_res = in_a;
        end else if (v == '0) begin
            s1_d.spec_res = {(rnd == RDN), {(FP_W-1){1'b0}}};
        end else begin
            s1_d.special = 1'b0;
        end
    end

    // S2: normalising shift (hidden bit dropped), rounding increment, base exponent
    always_comb begin
        logic [LZ_W-1:0]    shamt;
        logic [ALIGN_W-2:0] norm;
        logic               shout, g, r, st, lsb, inc;
        logic [MAN_W:0]     mant;
        shamt = (s1_q.lz == '0) ? '0 : s1_q.lz - LZ_W'(1);
        if (s1_q.lz == '0) begin
            norm  = s1_q.sum[ALIGN_W-1:1];
            shout = s1_q.sum[0];
        end else begin
            norm  = (ALIGN_W-1)'(s1_q.sum << shamt);
            shout = 1'b0;
        end
        g   = norm[7];
        r   = norm[6];
        st  = (|norm[5:0]) | shout;
        lsb = norm[8];
        inc = 1'b0;
        case (s1_q.rnd)
            RNE:     inc = g & (r | st | lsb);
            RUP:     inc = ~s1_q.sign & (g | r | st);
            RDN:     inc = s1_q.sign & (g | r | st);
            default: inc = 1'b0;
        endcase
        mant = {1'b0, norm[ALIGN_W-2:8]} + (MAN_W+1)'(inc);
        s2_d = '0;
        s2_d.special      = s1_q.special;
        s2_d.spec_res     = s1_q.spec_res;
        s2_d.spec_invalid = s1_q.spec_invalid;
        s2_d.sign         = s1_q.sign;
        s2_d.e            = EW'(s1_q.exp) + EW'(s1_q.carry) - EW'(shamt);
        s2_d.field        = mant[MAN_W-1:0];
        s2_d.rcarry       = mant[MAN_W];
        s2_d.inexact      = g | r | st;
        s2_d.rnd          = s1_q.rnd;
    end

    // S3: round-carry exponent bump, overflow/underflow handling, pack
    always_comb begin
        logic [EW-1:0] e_adj;
        logic ovf, unf, to_inf;
        e_adj  = s2_q.e + EW'(s2_q.rcarry);
        ovf    = ~e_adj[EW-1] & (e_adj >= EW'(EXP_MAX));
        unf    = e_adj[EW-1] | (e_adj == '0);
        to_inf = (s2_q.rnd == RNE) | ((s2_q.rnd == RUP) & ~s2_q.sign)
               | ((s2_q.rnd == RDN) & s2_q.sign);
        res_d   = '0;
        flags_d = '0;
        if (s2_q.special) begin
            res_d           = s2_q.spec_res;
            flags_d.invalid = s2_q.spec_invalid;
        end else if (ovf) begin
            flags_d.overflow = 1'b1;
            flags_d.inexact  = 1'b1;
            res_d = to_inf ? FP_W'(fp_inf(s2_q.sign, EXP_W, MAN_W))
                           : FP_W'(fp_max_finite(s2_q.sign, EXP_W, MAN_W));
        end else if (unf) begin
            flags_d.underflow = 1'b1;
            flags_d.inexact   = 1'b1;
            res_d = {s2_q.sign, {(FP_W-1){1'b0}}};
        end else begin
            res_d           = {s2_q.sign, e_adj[EXP_W-1:0], s2_q.field};
            flags_d.inexact = s2_q.inexact;
        end
    end

    // Each stage loads when empty or when its current beat moves on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (ready2) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_q <= s2_d;
            end
            if (ready3) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_result <= res_d;
                    out_flags  <= flags_d;
                end
            end
        end
    end

endmodule
